// File: rtl/sprite_compositor.sv
// Sprite compositor: per-pixel sprite ROM addressing, colour-key transparency, index-priority
// overlay on the background, and a per-frame sprite collision flag. Config is committed at frame_start.
module sprite_compositor #(
  parameter int                 NUM_SPR   = 8,
  parameter int                 XW        = 10,
  parameter int                 YW        = 9,
  parameter int                 ADDR_W    = 14,
  parameter int                 COLOR_W   = 12,
  parameter int                 ROM_LAT   = 1,
  parameter logic [COLOR_W-1:0] TRANS_KEY = 12'h428
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       frame_start,
  input  logic                       pix_valid,
  input  logic [XW-1:0]              col_addr,
  input  logic [YW-1:0]              row_addr,
  input  logic [COLOR_W-1:0]         bg_pixel,
  input  logic                       cfg_we,
  input  logic [3:0]                 cfg_idx,
  input  logic [XW-1:0]              cfg_x,
  input  logic [YW-1:0]              cfg_y,
  input  logic [XW-1:0]              cfg_w,
  input  logic [YW-1:0]              cfg_h,
  output logic [NUM_SPR*ADDR_W-1:0]  spr_addr,
  input  logic [NUM_SPR*COLOR_W-1:0] spr_data,
  output logic [COLOR_W-1:0]         pix_out,
  output logic                       pix_out_valid,
  output logic [NUM_SPR-1:0]         hit_mask,
  output logic                       coll_frame
);

  localparam int FW = XW + YW + 1;

  logic [XW-1:0] sh_x [NUM_SPR];
  logic [YW-1:0] sh_y [NUM_SPR];
  logic [XW-1:0] sh_w [NUM_SPR];
  logic [YW-1:0] sh_h [NUM_SPR];
  logic [XW-1:0] ac_x [NUM_SPR];
  logic [YW-1:0] ac_y [NUM_SPR];
  logic [XW-1:0] ac_w [NUM_SPR];
  logic [YW-1:0] ac_h [NUM_SPR];

  // Commit reads the shadow before any same-cycle write lands, so such a write waits a frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        sh_x[i] <= '0;
        sh_y[i] <= '0;
        sh_w[i] <= '0;
        sh_h[i] <= '0;
        ac_x[i] <= '0;
        ac_y[i] <= '0;
        ac_w[i] <= '0;
        ac_h[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SPR; i++) begin
        if (frame_start) begin
          ac_x[i] <= sh_x[i];
          ac_y[i] <= sh_y[i];
          ac_w[i] <= sh_w[i];
          ac_h[i] <= sh_h[i];
        end
        if (cfg_we && (cfg_idx == 4'(i))) begin
          sh_x[i] <= cfg_x;
          sh_y[i] <= cfg_y;
          sh_w[i] <= cfg_w;
          sh_h[i] <= cfg_h;
        end
      end
    end
  end

  logic [NUM_SPR-1:0] in_box_c;
  logic [XW-1:0]      dx_c  [NUM_SPR];
  logic [YW-1:0]      dy_c  [NUM_SPR];
  logic [FW-1:0]      lin_c [NUM_SPR];

  // Box end is formed one bit wider so a sprite hanging off the right/bottom edge never wraps to 0.
  always_comb begin
    in_box_c = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      in_box_c[i] = (ac_w[i] != '0) && (ac_h[i] != '0)
                 && (col_addr >= ac_x[i])
                 && ({1'b0, col_addr} < ({1'b0, ac_x[i]} + {1'b0, ac_w[i]}))
                 && (row_addr >= ac_y[i])
                 && ({1'b0, row_addr} < ({1'b0, ac_y[i]} + {1'b0, ac_h[i]}));
      dx_c[i]  = col_addr - ac_x[i];
      dy_c[i]  = row_addr - ac_y[i];
      lin_c[i] = FW'(dy_c[i]) * FW'(ac_w[i]) + FW'(dx_c[i]);
    end
  end

  logic [NUM_SPR-1:0] in_box_q;
  logic               pv_q;
  logic [COLOR_W-1:0] bg_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spr_addr <= '0;
      in_box_q <= '0;
      pv_q     <= 1'b0;
      bg_q     <= '0;
    end else begin
      in_box_q <= in_box_c;
      pv_q     <= pix_valid;
      bg_q     <= bg_pixel;
      for (int i = 0; i < NUM_SPR; i++)
        spr_addr[i*ADDR_W +: ADDR_W] <= in_box_c[i] ? ADDR_W'(lin_c[i]) : '0;
    end
  end

  logic [NUM_SPR-1:0] box_d [ROM_LAT];
  logic               pv_d  [ROM_LAT];
  logic [COLOR_W-1:0] bg_d  [ROM_LAT];

  // Side-band flags ride alongside the ROM read so they line up with spr_data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < ROM_LAT; k++) begin
        box_d[k] <= '0;
        pv_d[k]  <= 1'b0;
        bg_d[k]  <= '0;
      end
    end else begin
      box_d[0] <= in_box_q;
      pv_d[0]  <= pv_q;
      bg_d[0]  <= bg_q;
      for (int k = 1; k < ROM_LAT; k++) begin
        box_d[k] <= box_d[k-1];
        pv_d[k]  <= pv_d[k-1];
        bg_d[k]  <= bg_d[k-1];
      end
    end
  end

  logic [NUM_SPR-1:0] opq_c;
  logic [COLOR_W-1:0] pix_c;
  logic               pv_o;
  logic               multi_c;

  assign pv_o = pv_d[ROM_LAT-1];

  always_comb begin
    opq_c = '0;
    pix_c = bg_d[ROM_LAT-1];
    for (int i = 0; i < NUM_SPR; i++) begin
      opq_c[i] = box_d[ROM_LAT-1][i] && (spr_data[i*COLOR_W +: COLOR_W] != TRANS_KEY);
      if (opq_c[i])
        pix_c = spr_data[i*COLOR_W +: COLOR_W];
    end
  end

  // Clearing the lowest set bit leaves something only when two or more sprites are opaque.
  assign multi_c = |(opq_c & (opq_c - NUM_SPR'(1)));

  logic sticky;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_out       <= '0;
      pix_out_valid <= 1'b0;
      hit_mask      <= '0;
      sticky        <= 1'b0;
      coll_frame    <= 1'b0;
    end else begin
      pix_out       <= pix_c;
      pix_out_valid <= pv_o;
      hit_mask      <= pv_o ? opq_c : '0;
      if (frame_start) begin
        coll_frame <= sticky;
        sticky     <= pv_o && multi_c;
      end else if (pv_o && multi_c) begin
        sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: frame-level behavioural model with a per-cycle compare
// process, plus hand-computed literal expectations at key points.
module tb_sprite_compositor;

  localparam int N   = 8;
  localparam int AW  = 14;
  localparam int CW  = 12;
  localparam int LAT = 3;
  localparam logic [11:0] KEY = 12'h428;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic            frame_start = 1'b0;
  logic            pix_valid = 1'b0;
  logic [9:0]      col_addr = '0;
  logic [8:0]      row_addr = '0;
  logic [11:0]     bg_pixel = '0;
  logic            cfg_we = 1'b0;
  logic [3:0]      cfg_idx = '0;
  logic [9:0]      cfg_x = '0;
  logic [8:0]      cfg_y = '0;
  logic [9:0]      cfg_w = '0;
  logic [8:0]      cfg_h = '0;
  logic [N*AW-1:0] spr_addr;
  logic [N*CW-1:0] spr_data = '0;
  logic [11:0]     pix_out;
  logic            pix_out_valid;
  logic [N-1:0]    hit_mask;
  logic            coll_frame;

  sprite_compositor dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start), .pix_valid(pix_valid),
    .col_addr(col_addr), .row_addr(row_addr), .bg_pixel(bg_pixel),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_w(cfg_w), .cfg_h(cfg_h), .spr_addr(spr_addr), .spr_data(spr_data),
    .pix_out(pix_out), .pix_out_valid(pix_out_valid), .hit_mask(hit_mask),
    .coll_frame(coll_frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ec = 0;
  bit chk_on = 1'b0;

  int sh_x[N], sh_y[N], sh_w[N], sh_h[N];
  int ac_x[N], ac_y[N], ac_w[N], ac_h[N];
  bit trans_on[N];
  int trans_a[N];

  logic [N*AW-1:0] exp_addr [4096];
  bit              exp_v    [4096];
  logic [11:0]     exp_pix  [4096];
  logic [7:0]      exp_hit  [4096];
  bit              fs_at    [4096];
  bit              m_sticky;
  bit              exp_coll;

  // Sprite ROM contents: distinct per sprite/address, never equal to the key unless forced.
  function automatic logic [11:0] rom_val(int i, int a);
    if (trans_on[i] && (a == trans_a[i])) return KEY;
    return 12'(32'h800 | (i << 7) | (a & 127));
  endfunction

  always @(posedge clk)
    for (int i = 0; i < N; i++)
      spr_data[i*CW +: CW] <= rom_val(i, int'(spr_addr[i*AW +: AW]));

  always @(posedge clk) ec <= ec + 1;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_w[i] = 0; sh_h[i] = 0;
      ac_x[i] = 0; ac_y[i] = 0; ac_w[i] = 0; ac_h[i] = 0;
    end
    for (int k = 0; k < 4096; k++) begin
      exp_addr[k] = '0; exp_v[k] = 1'b0; exp_pix[k] = '0; exp_hit[k] = '0; fs_at[k] = 1'b0;
    end
    m_sticky = 1'b0;
    exp_coll = 1'b0;
  endtask

  // One clock of stimulus; the model predicts what the DUT shows after the next edge and later.
  task automatic cycle(bit v, int col, int row, logic [11:0] bg, bit fs, bit we,
                       int idx, int x, int y, int w, int h);
    int n, a;
    logic [11:0] pix, d;
    logic [7:0] hit;
    logic [N*AW-1:0] av;
    @(negedge clk);
    pix_valid = v; col_addr = 10'(col); row_addr = 9'(row); bg_pixel = bg;
    frame_start = fs; cfg_we = we; cfg_idx = 4'(idx);
    cfg_x = 10'(x); cfg_y = 9'(y); cfg_w = 10'(w); cfg_h = 9'(h);
    n = ec + 1;
    pix = bg; hit = '0; av = '0;
    for (int i = 0; i < N; i++) begin
      if (ac_w[i] != 0 && ac_h[i] != 0 && col >= ac_x[i] && col < ac_x[i] + ac_w[i]
          && row >= ac_y[i] && row < ac_y[i] + ac_h[i]) begin
        a = ((row - ac_y[i]) * ac_w[i] + (col - ac_x[i])) % (1 << AW);
        av[i*AW +: AW] = AW'(a);
        d = rom_val(i, a);
        if (d != KEY) begin
          hit[i] = 1'b1;
          pix = d;
        end
      end
    end
    exp_addr[n] = av;
    fs_at[n] = fs;
    exp_v[n+LAT-1] = v;
    exp_pix[n+LAT-1] = pix;
    exp_hit[n+LAT-1] = v ? hit : 8'h00;
    if (fs)
      for (int i = 0; i < N; i++) begin
        ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_w[i] = sh_w[i]; ac_h[i] = sh_h[i];
      end
    if (we && idx < N) begin
      sh_x[idx] = x; sh_y[idx] = y; sh_w[idx] = w; sh_h[idx] = h;
    end
  endtask

  task automatic pixel(int col, int row, logic [11:0] bg);
    cycle(1'b1, col, row, bg, 1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(int k);
    repeat (k) cycle(1'b0, 0, 0, 12'h000, 1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic fstart();
    cycle(1'b0, 0, 0, 12'h000, 1'b1, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg(int idx, int x, int y, int w, int h, bit fs);
    cycle(1'b0, 0, 0, 12'h000, fs, 1'b1, idx, x, y, w, h);
  endtask

  // Per-cycle comparison against the model; collision flag tracked at frame granularity.
  always @(negedge clk) begin
    int m;
    bit contrib;
    if (!rstn) begin
      chk("rst_valid", 128'(pix_out_valid), 128'(0));
      chk("rst_hit", 128'(hit_mask), 128'(0));
      chk("rst_coll", 128'(coll_frame), 128'(0));
      chk("rst_addr", 128'(spr_addr), 128'(0));
    end else if (chk_on) begin
      m = ec;
      chk("addr", 128'(spr_addr), 128'(exp_addr[m]));
      chk("valid", 128'(pix_out_valid), 128'(exp_v[m]));
      chk("hit", 128'(hit_mask), 128'(exp_hit[m]));
      if (exp_v[m]) chk("pix", 128'(pix_out), 128'(exp_pix[m]));
      contrib = exp_v[m] && ($countones(exp_hit[m]) >= 2);
      if (fs_at[m]) begin
        exp_coll = m_sticky;
        m_sticky = contrib;
      end else begin
        m_sticky = m_sticky | contrib;
      end
      chk("coll", 128'(coll_frame), 128'(exp_coll));
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      trans_on[i] = 1'b0;
      trans_a[i] = 0;
    end
    model_clear();
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("t0_rst_pix", 128'(pix_out), 128'(0));
    @(posedge clk);
    #2 rstn = 1'b1;
    chk_on = 1'b1;

    // basic hit and address
    cfg(0, 10, 20, 4, 2, 1'b0);
    fstart();
    pixel(12, 21, 12'h111);
    idle(1);
    chk("t1_addr0", 128'(spr_addr[13:0]), 128'(6));
    idle(2);
    chk("t1_pix", 128'(pix_out), 128'(12'h806));
    chk("t1_hit", 128'(hit_mask), 128'(8'h01));

    // transparent key falls through to background
    trans_on[0] = 1'b1; trans_a[0] = 6;
    pixel(12, 21, 12'h222);
    idle(3);
    chk("t2_pix", 128'(pix_out), 128'(12'h222));
    chk("t2_hit", 128'(hit_mask), 128'(8'h00));
    trans_on[0] = 1'b0;

    // priority and collision
    cfg(1, 3, 3, 4, 4, 1'b0);
    cfg(3, 5, 5, 2, 2, 1'b0);
    fstart();
    pixel(5, 5, 12'h333);
    idle(3);
    chk("t3_pix", 128'(pix_out), 128'(12'h980));
    chk("t3_hit", 128'(hit_mask), 128'(8'h0A));
    fstart();
    idle(1);
    chk("t3_coll_set", 128'(coll_frame), 128'(1));
    pixel(3, 3, 12'h334);
    idle(3);
    fstart();
    idle(1);
    chk("t3_coll_clr", 128'(coll_frame), 128'(0));

    // double-buffered moves
    cfg(0, 100, 100, 4, 2, 1'b0);
    pixel(12, 21, 12'h444);
    idle(3);
    chk("t4_old_pos", 128'(pix_out), 128'(12'h806));
    fstart();
    pixel(12, 21, 12'h555);
    idle(3);
    chk("t4_left_old", 128'(pix_out), 128'(12'h555));
    pixel(101, 100, 12'h666);
    idle(3);
    chk("t4_new_pos", 128'(pix_out), 128'(12'h801));
    cfg(0, 200, 50, 4, 2, 1'b1);
    pixel(101, 100, 12'h777);
    idle(3);
    chk("t4_coinc_hold", 128'(pix_out), 128'(12'h801));
    fstart();
    pixel(201, 50, 12'h888);
    idle(3);
    chk("t4_coinc_late", 128'(pix_out), 128'(12'h801));
    pixel(101, 100, 12'h999);
    idle(3);
    chk("t4_coinc_old", 128'(pix_out), 128'(12'h999));

    // edges: no wrap, w=0, out-of-range index
    cfg(2, 1014, 0, 20, 4, 1'b0);
    cfg(4, 0, 0, 0, 4, 1'b0);
    cfg(8, 0, 0, 4, 4, 1'b0);
    cfg(15, 0, 0, 4, 4, 1'b0);
    fstart();
    pixel(0, 1, 12'hAAA);
    idle(3);
    chk("t5_nowrap", 128'(pix_out), 128'(12'hAAA));
    pixel(1023, 3, 12'hBBB);
    idle(3);
    chk("t5_corner", 128'(pix_out), 128'(12'h945));
    chk("t5_corner_hit", 128'(hit_mask), 128'(8'h04));
    pixel(1020, 4, 12'hCCC);
    idle(3);
    chk("t5_row_end", 128'(pix_out), 128'(12'hCCC));
    pixel(0, 0, 12'hDDD);
    idle(3);
    chk("t5_w0", 128'(hit_mask), 128'(8'h00));
    pixel(1, 1, 12'hEEE);
    idle(3);
    chk("t5_idx_ign", 128'(pix_out), 128'(12'hEEE));

    // reset with pixels in flight
    pixel(5, 5, 12'h123);
    idle(3);
    fstart();
    idle(1);
    chk("t6_coll_pre", 128'(coll_frame), 128'(1));
    pixel(1020, 1, 12'h124);
    pixel(5, 5, 12'h125);
    @(posedge clk);
    #2 rstn = 1'b0;
    pix_valid = 1'b0; frame_start = 1'b0; cfg_we = 1'b0;
    model_clear();
    @(negedge clk);
    chk("t6_valid", 128'(pix_out_valid), 128'(0));
    chk("t6_coll", 128'(coll_frame), 128'(0));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;
    pixel(5, 5, 12'h321);
    idle(3);
    chk("t6_act_clr", 128'(pix_out), 128'(12'h321));
    chk("t6_act_hit", 128'(hit_mask), 128'(8'h00));
    fstart();
    pixel(5, 5, 12'h654);
    idle(3);
    chk("t6_sh_clr", 128'(pix_out), 128'(12'h654));

    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
